sev_seg_scan: RTL and testbench
===============================

SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles per digit period (minimum 4).
REQ-003 Parameter BLANK_CYCLES, default 2, SHALL set the anti-ghost cycles at each digit-period start (legal range 0..REFRESH_DIV-1).
REQ-004 Parameter ANODE_ACTIVE_LOW, default 1, SHALL set anode polarity: 1 means an active digit is driven 0.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-007 Port value, input, 4*NUM_DIGITS bits, SHALL carry hex nibbles; digit 0 is bits [3:0] (least significant digit).
REQ-008 Port dp_in, input, NUM_DIGITS bits, SHALL carry per-digit decimal-point requests (1 means on).
REQ-009 Port load, input, 1 bit, SHALL be a single-cycle strobe that captures value and dp_in.
REQ-010 Port segment, output, 8 bits, SHALL be the active-low pattern: bit7 is dp, bits6..0 are g..a.
REQ-011 Port anode, output, NUM_DIGITS bits, SHALL be the one-hot digit enable in ANODE_ACTIVE_LOW polarity.
REQ-012 Port frame, output, 1 bit, SHALL pulse high for one cycle each time the digit index wraps to 0.

Function
REQ-013 A period counter SHALL count 0..REFRESH_DIV-1 and wrap; the digit index SHALL advance on the wrap cycle, going from NUM_DIGITS-1 to 0.
REQ-014 load SHALL write value/dp_in into a pending register and set a pending flag; a later load before frame SHALL overwrite it (last wins).
REQ-015 The display register SHALL update from pending only on the cycle the index wraps to 0 (frame-coherent, no tearing); pending SHALL clear then.
REQ-016 load coincident with the wrap-to-0 cycle SHALL bypass: that cycle's value/dp_in goes directly to the display register, and pending clears.
REQ-017 The nibble-to-segment map SHALL be 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (hex, bit7=1).
REQ-018 segment[7] SHALL be the inverse of the displayed digit's dp bit.
REQ-019 segment and anode SHALL be registered, appearing one cycle after the index/counter state that selects them.
REQ-020 While the counter is below BLANK_CYCLES, anode SHALL be all-inactive and segment SHALL be FF.
REQ-021 frame SHALL be registered, aligned with the first cycle in which the new digit 0 is selected at the outputs.

Reset
REQ-022 rst SHALL clear the counter, index, pending flag, pending register and display register to 0.
REQ-023 rst SHALL drive segment to FF, anode to all-inactive and frame to 0 on the following edge.
REQ-024 rst mid-period SHALL abandon the current period, and a pending load SHALL be discarded.
REQ-025 load asserted together with rst SHALL be ignored.

Configuration
REQ-026 Macro SEV_SEG_LZB_EN, when defined, SHALL enable leading-zero blanking.
REQ-027 With SEV_SEG_LZB_EN: zero digits above the most significant nonzero digit SHALL drive FF with their anode still active, and dp SHALL be suppressed on those digits.
REQ-028 With SEV_SEG_LZB_EN, digit 0 SHALL never be blanked.
REQ-029 Without SEV_SEG_LZB_EN, every digit SHALL be decoded per REQ-017 and no blanking logic SHALL be synthesised.

Structure
REQ-030 Package sev_seg_pkg SHALL hold the 16-entry segment constant table, SEG_BLANK (FF) and the digit-index width function (clog2 of NUM_DIGITS, minimum 1).
REQ-031 Sub-module sev_seg_dec (combinational nibble+dp to segment) SHALL be instantiated once, on the selected digit.

Verification
REQ-032 Bench parameters SHALL be NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ANODE_ACTIVE_LOW=1.
REQ-033 Reset test: rst held 3 cycles -> segment=FF, anode=1111, frame=0; the first digit-0 non-blank cycle occurs 2 cycles after rst drops.
REQ-034 Load test: load value=16'h12AF, dp_in=0100 -> next frame shows digit0=8E, 1=88, 2=24 (dp on), 3=F9 with anodes 1110, 1101, 1011, 0111.
REQ-035 Last-wins test: load 16'h1111 then load 16'h2222 within the same frame -> next frame shows A4 on all digits; 1111 is never displayed.
REQ-036 Bypass test: load 16'h0007 on the wrap-to-0 cycle -> that frame shows digit0=F8; with SEV_SEG_LZB_EN, digits 1..3=FF.
REQ-037 Mid-operation reset: rst during digit 2 with a load pending -> outputs blank; after release the display is 0000 (C0 on every digit, or with SEV_SEG_LZB_EN digits 1..3=FF and digit0=C0).

Source files
------------

// File: rtl/sev_seg_pkg.sv
// ============================================================================
// Module      : sev_seg_pkg
// Description : Shared constants for the seven-segment scanner: nibble to
//               segment table, blank pattern and digit-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sev_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low patterns, bit7 = dp (off), bits6..0 = g..a
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sev_seg_dec.sv
// ============================================================================
// Module      : sev_seg_dec
// Description : Combinational hex nibble plus decimal point to active-low
//               seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sev_seg_dec
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segment
);

    always_comb begin
        segment = {~dp, SEG_TABLE[nibble][6:0]};
    end

endmodule

`default_nettype wire

// File: rtl/sev_seg_scan.sv
// ============================================================================
// Module      : sev_seg_scan
// Description : Multiplexed seven-segment scanner with frame-coherent display
//               update, anti-ghost blanking and registered outputs.
//               Define SEV_SEG_LZB_EN to enable leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 2,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    output logic [7:0]                segment,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame
);

    localparam int                    c_cnt_w     = $clog2(REFRESH_DIV);
    localparam int                    c_idx_w     = idx_width(NUM_DIGITS);
    localparam logic [c_cnt_w-1:0]    c_cnt_max   = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_blank     = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0]    c_idx_max   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_anode_off = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_vld;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_frame_arm;

    logic                    w_wrap;
    logic                    w_frame_wrap;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic [7:0]              w_dec_seg;
    logic [7:0]              w_seg_sel;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_wrap       = (r_cnt == c_cnt_max);
    assign w_frame_wrap = w_wrap && (r_idx == c_idx_max);
    assign w_nib        = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_dp         = r_disp_dp[r_idx];

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    sev_seg_dec u_dec (
        .nibble  (w_nib),
        .dp      (w_dp),
        .segment (w_dec_seg)
    );

`ifdef SEV_SEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero
    logic [NUM_DIGITS-1:0] w_lead_zero;
    assign w_lead_zero[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign w_lead_zero[gi] = (r_disp_val[4*NUM_DIGITS-1:4*gi] == '0);
    end
    assign w_seg_sel = w_lead_zero[r_idx] ? SEG_BLANK : w_dec_seg;
`else
    assign w_seg_sel = w_dec_seg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_vld  <= 1'b0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
            r_frame_arm <= 1'b0;
            segment     <= SEG_BLANK;
            anode       <= c_anode_off;
            frame       <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + c_idx_w'(1);
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            // Display only changes at the frame boundary; a load on that
            // exact cycle takes effect immediately.
            if (w_frame_wrap) begin
                r_pend_vld <= 1'b0;
                if (load) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp_in;
                end else if (r_pend_vld) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end else if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end

            // Two stages so frame lines up with the registered digit-0 outputs
            r_frame_arm <= w_frame_wrap;
            frame       <= r_frame_arm;

            if (r_cnt < c_blank) begin
                segment <= SEG_BLANK;
                anode   <= c_anode_off;
            end else begin
                segment <= w_seg_sel;
                anode   <= ANODE_ACTIVE_LOW ? ~w_onehot : w_onehot;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sev_seg_scan.sv
// ============================================================================
// Module      : tb_sev_seg_scan
// Description : Directed scoreboard bench for sev_seg_scan (4 digits,
//               4-cycle digit period, 1 blank cycle, active-low anodes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sev_seg_scan;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
    } exp_t;

`ifdef SEV_SEG_LZB_EN
    localparam logic [7:0] c_lz = 8'hFF;
`else
    localparam logic [7:0] c_lz = 8'hC0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        frame;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sev_seg_scan #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .BLANK_CYCLES     (1),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .dp_in   (dp_in),
        .load    (load),
        .segment (segment),
        .anode   (anode),
        .frame   (frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        sb.push_back('{seg: s0, an: 4'b1110});
        sb.push_back('{seg: s1, an: 4'b1101});
        sb.push_back('{seg: s2, an: 4'b1011});
        sb.push_back('{seg: s3, an: 4'b0111});
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Frame offset 0 is the blank cycle of digit 0; digit d shows at 4d+1..4d+3
    task automatic check_frame(input string name);
        bit   ok;
        exp_t e;
        e = '0;
        wait_frame(ok);
        chk({name, "_frame_seen"}, 32'(ok), 32'd1);
        chk({name, "_blank_seg"}, 32'(segment), 32'hFF);
        chk({name, "_blank_an"}, 32'(anode), 32'hF);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (k == 1) chk({name, "_frame_width"}, 32'(frame), 32'd0);
            if (k % 4 == 0) begin
                chk({name, "_blank_seg"}, 32'(segment), 32'hFF);
                chk({name, "_blank_an"}, 32'(anode), 32'hF);
            end else begin
                if (k % 4 == 1) begin
                    chk({name, "_sb_avail"}, 32'(sb.size() != 0), 32'd1);
                    e = (sb.size() != 0) ? sb.pop_front() : '0;
                end
                chk({name, "_seg"}, 32'(segment), 32'(e.seg));
                chk({name, "_an"}, 32'(anode), 32'(e.an));
            end
        end
    endtask

    initial begin
        // Reset hold
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(segment), 32'hFF);
        chk("rst_an", 32'(anode), 32'hF);
        chk("rst_frame", 32'(frame), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_blank_seg", 32'(segment), 32'hFF);
        chk("post_rst_blank_an", 32'(anode), 32'hF);
        @(negedge clk);
        chk("post_rst_d0_seg", 32'(segment), 32'hC0);
        chk("post_rst_d0_an", 32'(anode), 32'hE);

        // Basic load with decimal point on digit 2
        value = 16'h12AF;
        dp_in = 4'b0100;
        load  = 1'b1;
        push_frame(8'h8E, 8'h88, 8'h24, 8'hF9);
        @(negedge clk);
        load  = 1'b0;
        dp_in = 4'b0000;
        check_frame("load");

        // Last wins: two loads inside one frame, after the wrap has passed
        value = 16'h1111;
        load  = 1'b1;
        @(negedge clk);
        value = 16'h2222;
        push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
        @(negedge clk);
        load = 1'b0;
        check_frame("last_wins");

        // Bypass: load on the wrap-to-0 cycle
        begin
            bit ok;
            wait_frame(ok);
            chk("bypass_sync", 32'(ok), 32'd1);
        end
        repeat (14) @(negedge clk);
        value = 16'h0007;
        load  = 1'b1;
        push_frame(8'hF8, c_lz, c_lz, c_lz);
        @(negedge clk);
        load = 1'b0;
        check_frame("bypass");

        // Mid-operation reset with a pending load, plus load during reset
        value = 16'h5555;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_seg", 32'(segment), 32'hFF);
        chk("mid_rst_an", 32'(anode), 32'hF);
        chk("mid_rst_frame", 32'(frame), 32'd0);
        value = 16'h9999;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("mid_rst_seg2", 32'(segment), 32'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_blank_seg", 32'(segment), 32'hFF);
        @(negedge clk);
        chk("mid_post_d0_seg", 32'(segment), 32'hC0);
        chk("mid_post_d0_an", 32'(anode), 32'hE);
        push_frame(8'hC0, c_lz, c_lz, c_lz);
        check_frame("mid_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
